// File: rtl/multdiv_sequencer_pkg.sv
// Shared decode constants, exception codes and state encoding for the mul/div sequencer.
package multdiv_sequencer_pkg;
  localparam logic [4:0]  OP_ALU          = 5'b00000;
  localparam logic [4:0]  ALU_MUL         = 5'b00110;
  localparam logic [4:0]  ALU_DIV         = 5'b00111;
  localparam int          RSTATUS_REG_DEF = 30;
  localparam logic [31:0] EXC_MUL         = 32'd4;
  localparam logic [31:0] EXC_DIV         = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } md_state_e;
endpackage

// File: rtl/md_cycle_counter.sv
// Saturating BUSY-cycle counter with a timeout terminal-count flag.
module md_cycle_counter
  import multdiv_sequencer_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // cnt counts completed BUSY cycles; tc flags the cycle whose edge brings it to TIMEOUT
  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);

  // clear has priority; increment stops at all-ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (en && (cnt != CNT_MAX))  cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == TC_VAL);
endmodule

// File: rtl/multdiv_sequencer.sv
// Freezes the pipeline around a mul/div in DX, drives the shared unit and returns one result beat.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT     = 40,
  parameter int CNT_W       = 6,
  parameter int RSTATUS_REG = RSTATUS_REG_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_insn,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_reg,
  output logic        res_timeout
);
  md_state_e        state_q, state_d;
  logic             is_alu, is_mul, is_div, is_md;
  logic             div_q, exc_q;
  logic [4:0]       rd_q;
  logic [31:0]      result_q;
  logic             cnt_clr, cnt_en, tc;
  logic [CNT_W-1:0] cnt;
  logic             unused_insn;

  assign is_alu      = dx_insn[31:27] == OP_ALU;
  assign is_mul      = is_alu && (dx_insn[6:2] == ALU_MUL);
  assign is_div      = is_alu && (dx_insn[6:2] == ALU_DIV);
  assign is_md       = is_mul | is_div;
  assign unused_insn = ^{dx_insn[21:7], dx_insn[1:0]};

  md_cycle_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state, stall/start/result strobes; flush always wins and drops stall
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    res_valid     = 1'b0;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // reset gating keeps stall low while the block is held in reset
        if (is_md && !flush) begin
          stall   = reset;
          cnt_clr = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall  = 1'b1;
          cnt_en = 1'b1;
          // counter is cleared on entry, so cnt==0 marks the first BUSY cycle
          md_start_mult = (cnt == '0) && !div_q;
          md_start_div  = (cnt == '0) &&  div_q;
          if (md_ready || tc) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = !flush;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // operand/destination latch on detect; result or forced exception capture in BUSY
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_opA      <= '0;
      md_opB      <= '0;
      div_q       <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && is_md && !flush) begin
        md_opA <= dx_opA;
        md_opB <= dx_opB;
        div_q  <= is_div;
        rd_q   <= dx_insn[26:22];
      end
      if (state_q == ST_BUSY && !flush) begin
        if (md_ready) begin
          result_q <= md_result;
          exc_q    <= md_exception;
        end else if (tc) begin
          exc_q       <= 1'b1;
          res_timeout <= 1'b1;
        end
      end
    end
  end

  assign res_reg  = !res_valid ? 5'd0  : (exc_q ? 5'(RSTATUS_REG) : rd_q);
  assign res_data = !res_valid ? 32'd0 : (exc_q ? (div_q ? EXC_DIV : EXC_MUL) : result_q);
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed scoreboard bench: stimulus pushes expected starts/results, monitors pop and compare.
module tb_multdiv_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_insn, dx_opA, dx_opB, md_result;
  logic        flush, md_ready, md_exception;
  logic        md_start_mult, md_start_div, stall, res_valid, res_timeout;
  logic [31:0] md_opA, md_opB, res_data;
  logic [4:0]  res_reg;

  typedef struct packed { logic dv; logic [31:0] a; logic [31:0] b; } start_t;
  typedef struct packed { logic [4:0] rg; logic [31:0] d; } res_t;

  start_t start_q[$];
  res_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  multdiv_sequencer #(.TIMEOUT(40), .CNT_W(6), .RSTATUS_REG(30)) dut (
    .clock(clock), .reset(reset), .dx_insn(dx_insn), .dx_opA(dx_opA), .dx_opB(dx_opB),
    .flush(flush), .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
    .md_start_mult(md_start_mult), .md_start_div(md_start_div), .md_opA(md_opA), .md_opB(md_opB),
    .stall(stall), .res_valid(res_valid), .res_data(res_data), .res_reg(res_reg),
    .res_timeout(res_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] aop);
    mk = {5'b00000, rd, 15'd0, aop, 2'b00};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // start pulse monitor
  always @(negedge clock) begin
    if (md_start_mult || md_start_div) begin
      chk1("start_one_hot", md_start_mult & md_start_div, 1'b0);
      if (start_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL start_unexpected: got start m=%0b d=%0b expected none", md_start_mult, md_start_div);
      end else begin
        start_t e;
        e = start_q.pop_front();
        chk1("start_kind", md_start_div, e.dv);
        chk32("start_opA", md_opA, e.a);
        chk32("start_opB", md_opB, e.b);
      end
    end
  end

  // result monitor
  always @(negedge clock) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL res_unexpected: got res_valid reg=%0d data=0x%08h expected none", res_reg, res_data);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk32("res_reg", 32'(res_reg), 32'(e.rg));
        chk32("res_data", res_data, e.d);
      end
    end
  end

  // one mul/div from detect to the cycle after DONE; k BUSY cycles precede the ready/last BUSY cycle
  task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                       input int k, input bit rdy, input bit exc, input logic [31:0] res,
                       input logic [4:0] ereg, input logic [31:0] edata, input bit dv);
    dx_insn = insn; dx_opA = a; dx_opB = b;
    start_q.push_back({dv, a, b});
    exp_q.push_back({ereg, edata});
    #1 chk1("stall_detect", stall, 1'b1);
    tick();
    for (int i = 0; i < k; i++) begin
      chk1("stall_busy", stall, 1'b1);
      tick();
    end
    if (rdy) begin md_ready = 1'b1; md_result = res; md_exception = exc; end
    #1 chk1("stall_last", stall, 1'b1);
    tick();
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    #1 chk1("stall_done", stall, 1'b0);
    tick();
    dx_insn = NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    md_result = '0; dx_opA = '0; dx_opB = '0;
    dx_insn = mk(5'd3, 5'b00110);
    #2;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_start", md_start_mult | md_start_div, 1'b0);
    chk1("rst_valid", res_valid, 1'b0);
    chk1("rst_timeout", res_timeout, 1'b0);
    chk32("rst_opA", md_opA, 32'd0);
    dx_insn = NOP;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // mul 7 * -6, k=16
    do_op(mk(5'd3, 5'b00110), 32'd7, -32'sd6, 16, 1'b1, 1'b0, -32'sd42, 5'd3, -32'sd42, 1'b0);
    // div by zero with unit exception
    do_op(mk(5'd9, 5'b00111), 32'd1, 32'd0, 3, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd30, 32'd5, 1'b1);
    // timeout: unit never ready, 40 BUSY cycles
    chk1("timeout_pre", res_timeout, 1'b0);
    do_op(mk(5'd4, 5'b00110), 32'd2, 32'd3, 39, 1'b0, 1'b0, 32'd0, 5'd30, 32'd4, 1'b0);
    chk1("timeout_sticky", res_timeout, 1'b1);

    // flush in the 5th BUSY cycle, late md_ready must be ignored
    dx_insn = mk(5'd5, 5'b00110); dx_opA = 32'd11; dx_opB = 32'd12;
    start_q.push_back({1'b0, 32'd11, 32'd12});
    #1 chk1("fl_detect", stall, 1'b1);
    repeat (5) tick();
    flush = 1'b1;
    #1 chk1("fl_stall_drop", stall, 1'b0);
    tick();
    flush = 1'b0; dx_insn = NOP;
    repeat (2) tick();
    md_ready = 1'b1; md_result = 32'd123;
    #1 chk1("fl_idle_ready", stall, 1'b0);
    tick();
    md_ready = 1'b0; md_result = 32'd0;
    repeat (3) begin chk1("fl_idle", stall, 1'b0); tick(); end

    // back-to-back mul then div
    do_op(mk(5'd1, 5'b00110), 32'd3, 32'd5, 10, 1'b1, 1'b0, 32'd15, 5'd1, 32'd15, 1'b0);
    do_op(mk(5'd2, 5'b00111), 32'd100, 32'd7, 10, 1'b1, 1'b0, 32'd14, 5'd2, 32'd14, 1'b1);

    // async reset mid-BUSY
    dx_insn = mk(5'd6, 5'b00110); dx_opA = 32'd9; dx_opB = 32'd9;
    start_q.push_back({1'b0, 32'd9, 32'd9});
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    chk1("ar_stall", stall, 1'b0);
    chk1("ar_timeout", res_timeout, 1'b0);
    chk1("ar_start", md_start_mult | md_start_div, 1'b0);
    chk1("ar_valid", res_valid, 1'b0);
    chk32("ar_opA", md_opA, 32'd0);
    chk32("ar_opB", md_opB, 32'd0);
    tick();
    dx_insn = mk(5'd7, 5'b00000);
    reset = 1'b1;
    #1 chk1("add_nostall", stall, 1'b0);
    tick();
    chk1("add_nostall2", stall, 1'b0);

    repeat (3) tick();
    chk32("start_q_drained", start_q.size(), 32'd0);
    chk32("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
